// File: rtl/procyon_rr_ff_arbiter.sv
// procyon_rr_ff_arbiter: round-robin arbiter with burst lock that feeds one registered output slot.
// Optional stall counter is built when PROCYON_RR_ARB_STALL_CNT_EN is defined.
module procyon_rr_ff_arbiter #(
  parameter int OPTN_NUM_REQ    = 4,
  parameter int OPTN_DATA_WIDTH = 32,
  parameter int OPTN_CNT_WIDTH  = 16
) (
  input  logic                                    clk,
  input  logic                                    n_rst,
  input  logic [OPTN_NUM_REQ-1:0]                 i_req_valid,
  input  logic [OPTN_NUM_REQ-1:0]                 i_req_last,
  input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0] i_req_data,
  output logic [OPTN_NUM_REQ-1:0]                 o_req_ready,
  output logic                                    o_valid,
  output logic                                    o_last,
  output logic [OPTN_DATA_WIDTH-1:0]              o_data,
  output logic [$clog2(OPTN_NUM_REQ)-1:0]         o_owner,
  input  logic                                    i_ready
`ifdef PROCYON_RR_ARB_STALL_CNT_EN
  ,
  input  logic                                    i_stall_clr,
  output logic [OPTN_CNT_WIDTH-1:0]               o_stall_cnt
`endif
);
  localparam int N  = OPTN_NUM_REQ;
  localparam int W  = OPTN_DATA_WIDTH;
  localparam int IW = $clog2(OPTN_NUM_REQ);

  typedef enum logic {ARB, LOCK} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, lock_q, lock_d;
  logic [IW-1:0] arb_gnt, gnt, gnt_nxt;
  logic          has_gnt, slot_free, load;
  logic          valid_q, last_q;
  logic [W-1:0]  data_q;
  logic [IW-1:0] owner_q;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IW'((s >= N) ? s - N : s);
  endfunction

  // Scan downward so the valid requester closest to the pointer wins.
  always_comb begin
    arb_gnt = ptr_q;
    for (int i = N - 1; i >= 0; i--)
      if (i_req_valid[wrap_add(ptr_q, i)]) arb_gnt = wrap_add(ptr_q, i);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = load ? (i_req_last[gnt] ? ARB : LOCK) : state_q;
    ptr_d   = (load & i_req_last[gnt]) ? gnt_nxt : ptr_q;
    lock_d  = load ? gnt : lock_q;
  end

  // A locked owner keeps the grant even while idle, so bursts are never split.
  always_comb begin
    gnt       = (state_q == LOCK) ? lock_q : arb_gnt;
    has_gnt   = (state_q == LOCK) | (|i_req_valid);
    gnt_nxt   = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
    slot_free = ~valid_q | i_ready;
    load      = slot_free & has_gnt & i_req_valid[gnt];
  end

  always_comb begin
    o_req_ready      = '0;
    o_req_ready[gnt] = load;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
    end else begin
      if (slot_free) valid_q <= load;
      if (load) begin
        data_q  <= i_req_data[gnt*W +: W];
        last_q  <= i_req_last[gnt];
        owner_q <= gnt;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_data  = data_q;
  assign o_owner = owner_q;

`ifdef PROCYON_RR_ARB_STALL_CNT_EN
  logic [OPTN_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb
    cnt_d = i_stall_clr ? '0 : ((valid_q & ~i_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;
`endif
endmodule

// File: doc/procyon_rr_ff_arbiter.md
Name: procyon_rr_ff_arbiter

Overview:
- Round-robin arbiter sharing one registered output slot (an enable-gated n-bit flip-flop stage) between OPTN_NUM_REQ requesters.
- Multi-beat transfers are supported: once a requester wins, it keeps the grant until its beat marked last is accepted.
- Sits in front of shared single-port resources (e.g. a writeback or CSR write port) where several pipeline units compete for one registered write path.

Parameters:
- OPTN_NUM_REQ, 4, number of requesters (>=2).
- OPTN_DATA_WIDTH, 32, payload width per beat.
- OPTN_CNT_WIDTH, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- i_req_valid  in  OPTN_NUM_REQ  per-requester beat valid.
- i_req_last  in  OPTN_NUM_REQ  per-requester final-beat flag, qualified by i_req_valid.
- i_req_data  in  OPTN_NUM_REQ*OPTN_DATA_WIDTH  packed payloads; requester k occupies bits [k*W +: W].
- o_req_ready  out  OPTN_NUM_REQ  one-hot (or zero) beat accept, combinational.
- o_valid  out  1  output slot holds a beat.
- o_last  out  1  last flag of the held beat.
- o_data  out  OPTN_DATA_WIDTH  held payload (registered).
- o_owner  out  $clog2(OPTN_NUM_REQ)  index of the requester whose beat is held.
- i_ready  in  1  downstream consumes the held beat when o_valid & i_ready.

Behaviour:
- Reset (async, n_rst=0): o_valid=0, o_last=0, o_owner=0, o_data=0, rr pointer=0, FSM=ARB. Reset mid-transfer drops the held beat and releases the lock. Requesters must re-send.
- slot_free = ~o_valid | i_ready.
- Load enable: load = slot_free & i_req_valid[gnt] & (a grant exists).
- On load: the output register captures o_data, o_last and o_owner from the granted requester, and o_valid<=1.
- If slot_free and there is no load: o_valid<=0, and o_data holds its old value (don't-care).
- Throughput: 1 beat/cycle sustained. Latency: 1 cycle from the accept edge to o_valid.
- o_req_ready[k] = load & (gnt==k). It never asserts for a non-valid requester and never asserts for more than one bit.
- FSM states:
  - ARB: gnt = first k with i_req_valid[k], searching from the rr pointer upward with wrap (pointer, pointer+1, ..., N-1, 0, ...).
    - On load with i_req_last[gnt]=1: stay in ARB, pointer<=(gnt+1) mod N.
    - On load with i_req_last[gnt]=0: go to LOCK, lock_id<=gnt.
  - LOCK: gnt=lock_id only. Other requesters see ready=0 even while the lock owner is idle (bubbles allowed).
    - On load with i_req_last=1: go to ARB, pointer<=(lock_id+1) mod N.
- The pointer updates only on a completed transfer (last beat accepted), never on a stall.
- No valid requests in ARB: the pointer holds and o_req_ready=0.
- Backpressure (o_valid & ~i_ready): nothing loads, o_* are stable, and all ready=0.
- Simultaneous consume and load: the new beat replaces the old one in the same edge, with o_valid staying 1.
- Pointer wrap: gnt=N-1 with last sets pointer to 0.
- Requester contract (not checked): i_req_data and i_req_last stay stable while valid & ~ready.

Optional Feature:
- Macro PROCYON_RR_ARB_STALL_CNT_EN.
- When defined:
  - Extra output port o_stall_cnt [OPTN_CNT_WIDTH].
  - The counter increments each cycle where o_valid & ~i_ready, saturating at all-ones.
  - It clears on reset and on the input i_stall_clr (1 bit, also added). Clear wins over increment.
- When undefined: neither port exists and there is no counter logic. Arbitration behaviour is identical in both builds.

Test Plan:
- Single requester: N=4, req1 sends 3 beats (last on the 3rd), data 0xA,0xB,0xC, i_ready=1. Expected: ready[1] high 3 consecutive cycles, o_data 0xA,0xB,0xC on the following cycles, o_owner=1, pointer becomes 2.
- Round-robin fairness: all 4 valid with single-beat last=1, i_ready=1, pointer=0. Expected grant order 0,1,2,3,0, one per cycle.
- Lock hold: req2 sends a 4-beat burst while req0 and req3 are valid. Expected: req2 owns 4 beats, with no grant to 0/3 even during a 1-cycle req2 valid gap. Then req3 is granted next (pointer=3).
- Backpressure: o_valid=1 with data 0x55, i_ready=0 for 5 cycles, req0 valid. Expected: o_data stays 0x55 and ready=0 throughout. i_ready=1 then accepts req0 in the same cycle. With STALL_CNT_EN, o_stall_cnt=5.
- Reset mid-burst: assert n_rst low during LOCK on req1 beat 2. Expected: o_valid=0 immediately (async), then ARB with pointer=0, and the next grant goes to the lowest valid index.
- Stall counter (STALL_CNT_EN, OPTN_CNT_WIDTH=4): hold the stall 20 cycles. Expected: o_stall_cnt saturates at 15. i_stall_clr with a concurrent stall gives 0.
